z80_bus_cycle: RTL and testbench

//  Bus-master side of the Z80 memory bus: turns single-word requests from the CPU core into

---
 rtl/z80_bus_cycle.sv | 203 ++++++++++++++++++++
 tb/tb_z80_bus_cycle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_cycle.sv
// z80_bus_cycle: Z80 bus master sequencing opcode fetch (with refresh),
// memory read and memory write cycles, with wait states and timeout.
module z80_bus_cycle #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        i_reg,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              m1,
  output logic              mreq,
  output logic              rd,
  output logic              wr,
  output logic              rfsh,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wait_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4
  } state_t;

  localparam logic [1:0] TY_FETCH = 2'b00;
  localparam logic [1:0] TY_READ  = 2'b01;
  localparam logic [1:0] TY_WRITE = 2'b10;
  localparam logic [1:0] TY_RSVD  = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [6:0]        r_q, r_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              m1_q, m1_d;
  logic              mreq_q, mreq_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rfsh_q, rfsh_d;
  logic              oe_q, oe_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              to_t3;
  logic              abort;
  logic              limit_hit;
  logic [ADDR_W-1:0] rfsh_addr;

  assign limit_hit = ({1'b0, wcnt_q} + 9'd1) >= 9'(WAIT_LIMIT);
  assign rfsh_addr = ADDR_W'({i_reg, 1'b0, r_q});

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    r_d     = r_q;
    wcnt_d  = wcnt_q;
    m1_d    = m1_q;
    mreq_d  = mreq_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rfsh_d  = rfsh_q;
    oe_d    = oe_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    to_t3   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // ack_q blocks a still-held req so IDLE lasts a full cycle
        if (req && req_type != TY_RSVD && !ack_q) begin
          state_d = S_T1;
          type_d  = req_type;
          addr_d  = req_addr;
          wcnt_d  = '0;
          mreq_d  = 1'b0;
          m1_d    = req_type != TY_FETCH;
          rd_d    = req_type == TY_WRITE;
          if (req_type == TY_WRITE) begin
            dout_d = req_wdata;
            oe_d   = 1'b1;
          end
        end
      end
      S_T1: begin
        state_d = S_T2;
        wcnt_d  = '0;
        wr_d    = type_q != TY_WRITE;
      end
      S_T2: begin
        if (wait_n) to_t3 = 1'b1;
        else        state_d = S_TW;
      end
      S_TW: begin
        if (wait_n)         to_t3 = 1'b1;
        else if (limit_hit) abort = 1'b1;
        else                wcnt_d = wcnt_q + 8'd1;
      end
      S_T3: begin
        if (type_q == TY_FETCH) begin
          state_d = S_T4;
          mreq_d  = 1'b1;
          rfsh_d  = 1'b1;
          ack_d   = 1'b1;
          r_d     = r_q + 7'd1;
        end else begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
        end
      end
      S_T4: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (to_t3) begin
      state_d = S_T3;
      m1_d    = 1'b1;
      rd_d    = 1'b1;
      wr_d    = 1'b1;
      // fetch keeps mreq low into the refresh phase
      if (type_q == TY_FETCH) begin
        rdata_d = data_in;
        rfsh_d  = 1'b0;
        addr_d  = rfsh_addr;
      end else begin
        mreq_d = 1'b1;
        ack_d  = 1'b1;
        if (type_q == TY_READ) rdata_d = data_in;
      end
    end
    if (abort) begin
      state_d = S_IDLE;
      m1_d    = 1'b1;
      mreq_d  = 1'b1;
      rd_d    = 1'b1;
      wr_d    = 1'b1;
      rfsh_d  = 1'b1;
      oe_d    = 1'b0;
      ack_d   = 1'b1;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      type_q  <= TY_FETCH;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      r_q     <= '0;
      wcnt_q  <= '0;
      m1_q    <= 1'b1;
      mreq_q  <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      rfsh_q  <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      r_q     <= r_d;
      wcnt_q  <= wcnt_d;
      m1_q    <= m1_d;
      mreq_q  <= mreq_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rfsh_q  <= rfsh_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign m1       = m1_q;
  assign mreq     = mreq_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign rfsh     = rfsh_q;
  assign address  = addr_q;
  assign data_out = dout_q;
  assign data_oe  = oe_q;

endmodule

// File: tb/tb_z80_bus_cycle.sv
// tb_z80_bus_cycle: table-driven and random transactions against a
// timeline model of the Z80 bus cycles.
module tb_z80_bus_cycle;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic [7:0]  i_reg = 8'h0;
  logic [7:0]  data_in = 8'h0;
  logic        wait_n = 1'b1;
  logic        ack, err, m1, mreq, rd, wr, rfsh, data_oe;
  logic [7:0]  rdata, data_out;
  logic [15:0] address;
  logic [7:0]  bus;

  z80_bus_cycle #(.ADDR_W(16), .DATA_W(8), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .i_reg(i_reg),
    .ack(ack), .err(err), .rdata(rdata), .m1(m1), .mreq(mreq),
    .rd(rd), .wr(wr), .rfsh(rfsh), .address(address),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  assign bus = {m1, mreq, rd, wr, rfsh, data_oe, ack, err};

  int checks = 0;
  int failures = 0;
  int r_model = 0;
  logic [7:0] rdata_model = 8'h0;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic [7:0]  ir;
    int          n;
    int          exp_ack;
    logic        exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected strobes in cycle k after acceptance (T1 = 1) when wait_n
  // is held low for n samples.
  function automatic logic [7:0] exp_bus(input logic [1:0] t, input int k,
                                         input int n);
    bit ab;
    int tw, se, ak;
    bit acc;
    logic m, q, r, w, f, oe, a, e;
    ab  = n > LIM;
    tw  = ab ? LIM : n;
    se  = 2 + tw;
    ak  = (t == 2'b00 && !ab) ? se + 2 : se + 1;
    acc = k <= se;
    m = 1; q = 1; r = 1; w = 1; f = 1; oe = 0; a = 0; e = 0;
    if (k == ak) begin
      a = 1;
      e = ab;
    end
    case (t)
      2'b00: begin
        m = !acc;
        r = !acc;
        q = !(acc || (!ab && k == se + 1));
        f = !(!ab && k == se + 1);
      end
      2'b01: begin
        r = !acc;
        q = !acc;
      end
      default: begin
        q  = !acc;
        w  = !(acc && k >= 2);
        oe = acc || (!ab && k == ak);
      end
    endcase
    return {m, q, r, w, f, oe, a, e};
  endfunction

  // Called at a negedge in an idle cycle; returns at the negedge of
  // the idle cycle following ack.
  task automatic run_txn(input logic [1:0] t, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] din,
                         input int n, input logic [7:0] ir, input bit hold,
                         output int ack_at, output logic err_seen);
    bit ab;
    int tw, se, ak;
    logic [15:0] rf_addr;
    ab = n > LIM;
    tw = ab ? LIM : n;
    se = 2 + tw;
    ak = (t == 2'b00 && !ab) ? se + 2 : se + 1;
    rf_addr = {ir, 1'b0, 7'(r_model)};
    ack_at = 0;
    err_seen = 1'b0;
    req = 1'b1; req_type = t; req_addr = addr; req_wdata = wd;
    i_reg = ir; wait_n = 1'b1; data_in = ~din;
    for (int k = 1; k <= ak + 1; k++) begin
      @(negedge clk);
      if (ack === 1'b1 && ack_at == 0) begin
        ack_at = k;
        err_seen = err;
      end
      if (k == ak && !ab && t != 2'b10) rdata_model = din;
      if (k == ak && !ab && t == 2'b00) r_model = (r_model + 1) % 128;
      chk("bus", bus, exp_bus(t, k, n));
      if (k <= ak)
        chk("address", address, (t == 2'b00 && !ab && k > se) ? rf_addr : addr);
      if (t == 2'b10 && k <= ak) chk("data_out", data_out, wd);
      if (k == ak) chk("rdata", rdata, rdata_model);
      wait_n = !(k >= 2 && k <= n + 1);
      data_in = (k == se) ? din : ~din;
      if (k >= ak && !hold) req = 1'b0;
    end
  endtask

  vec_t tbl[9];
  int   ack_at;
  logic err_seen;

  initial begin
    tbl[0] = '{2'b00, 16'h0123, 8'h00, 8'h3E, 8'h12, 0, 4, 1'b0, 8'h3E};
    tbl[1] = '{2'b01, 16'h0FFF, 8'h00, 8'h77, 8'h00, 3, 6, 1'b0, 8'h77};
    tbl[2] = '{2'b10, 16'h0100, 8'hA5, 8'h11, 8'h00, 0, 3, 1'b0, 8'h77};
    tbl[3] = '{2'b01, 16'h2222, 8'h00, 8'h99, 8'h00, 9, 7, 1'b1, 8'h77};
    tbl[4] = '{2'b00, 16'h8000, 8'h00, 8'hC3, 8'hFE, 2, 6, 1'b0, 8'hC3};
    tbl[5] = '{2'b10, 16'hFFFF, 8'h5A, 8'h22, 8'h00, 4, 7, 1'b0, 8'hC3};
    tbl[6] = '{2'b00, 16'h4000, 8'h00, 8'h44, 8'h80, 5, 7, 1'b1, 8'hC3};
    tbl[7] = '{2'b10, 16'h1234, 8'h3C, 8'h33, 8'h00, 20, 7, 1'b1, 8'hC3};
    tbl[8] = '{2'b01, 16'hABCD, 8'h00, 8'h10, 8'h00, 1, 4, 1'b0, 8'h10};

    repeat (2) @(negedge clk);
    chk("reset_bus", bus, 8'hF8);
    chk("reset_addr", address, 16'h0);
    chk("reset_rdata", rdata, 8'h0);
    chk("reset_dout", data_out, 8'h0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      run_txn(tbl[i].t, tbl[i].addr, tbl[i].wd, tbl[i].din, tbl[i].n,
              tbl[i].ir, 1'b0, ack_at, err_seen);
      chk($sformatf("vec%0d_ack_cycle", i), ack_at, tbl[i].exp_ack);
      chk($sformatf("vec%0d_err", i), err_seen, tbl[i].exp_err);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
    end

    // reset in the middle of a write wait state
    req = 1'b1; req_type = 2'b10; req_addr = 16'h0100; req_wdata = 8'hA5;
    wait_n = 1'b1;
    @(negedge clk);
    wait_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_oe", data_oe, 1'b1);
    reset_n = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("midreset_bus", bus, 8'hF8);
    chk("midreset_addr", address, 16'h0);
    chk("midreset_dout", data_out, 8'h0);
    reset_n = 1'b1;
    wait_n = 1'b1;
    r_model = 0;
    rdata_model = 8'h0;

    // reserved request type must never start a cycle
    req = 1'b1; req_type = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rsvd_idle", bus, 8'hF8);
    end
    req = 1'b0;

    // refresh counter wrap across 130 fetches from R=0
    for (int i = 0; i < 130; i++) begin
      run_txn(2'b00, 16'(i * 3), 8'h00, 8'(i), 0, 8'($urandom),
              1'b0, ack_at, err_seen);
    end
    chk("r_wrapped", r_model, 2);

    for (int i = 0; i < 60; i++) begin
      run_txn(2'($urandom_range(0, 2)), 16'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 6), 8'($urandom),
              1'b0, ack_at, err_seen);
    end

    // req held through an aborted read's ack: IDLE, then a new T1
    run_txn(2'b01, 16'h4321, 8'h00, 8'h00, 7, 8'h00, 1'b1, ack_at, err_seen);
    chk("hold_err", err_seen, 1'b1);
    wait_n = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    chk("b2b_t1", bus, exp_bus(2'b01, 1, 0));
    chk("b2b_addr", address, 16'h4321);
    req = 1'b0;
    @(negedge clk);
    chk("b2b_t2", bus, exp_bus(2'b01, 2, 0));
    @(negedge clk);
    rdata_model = 8'h5A;
    chk("b2b_t3", bus, exp_bus(2'b01, 3, 0));
    chk("b2b_rdata", rdata, rdata_model);
    @(negedge clk);
    chk("b2b_idle", bus, 8'hF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
